// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and constant helpers for the multiplexed seven-segment scan controller.
// Slot and blink timing are derived from the clock rate here so every user agrees on them.
package display_pkg;

    // Decoder code that lights no segments.
    localparam logic [3:0] BLANK_CODE = 4'hF;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } scan_state_t;

    // Cycles per scan slot.
    function automatic int calc_div(input int clk_hz, input int scan_hz);
        return clk_hz / scan_hz;
    endfunction

    // Cycles per blink half-period.
    function automatic int calc_blink_half(input int clk_hz, input int blink_hz);
        return clk_hz / (2 * blink_hz);
    endfunction

    // Codes above 9 are not BCD and are shown blank.
    function automatic logic [3:0] blank_invalid(input logic [3:0] v);
        return (v > 4'd9) ? BLANK_CODE : v;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Signal bundle between the clock core (master) and the display scan controller (slave).
// No valid/ready handshake: inputs are level signals the slave samples only at frame starts.
interface display_scan_ctrl_if #(
    parameter int N_DIGITS = 6
);
    logic [4*N_DIGITS-1:0] digits;
    logic [N_DIGITS-1:0]   dp_in;
    logic [N_DIGITS-1:0]   blink_mask;
    logic                  lz_en;
    logic [3:0]            bcd_out;
    logic [N_DIGITS-1:0]   an;
    logic                  dp_out;
    logic                  frame_start;

    modport master (
        output digits, dp_in, blink_mask, lz_en,
        input  bcd_out, an, dp_out, frame_start
    );

    modport slave (
        input  digits, dp_in, blink_mask, lz_en,
        output bcd_out, an, dp_out, frame_start
    );
endinterface

// File: rtl/display_scan_ctrl_tick_divider.sv
// Modulus-MOD counter that emits a one-cycle tick on its last count while enabled.
// Used for both the scan-slot timer and the blink half-period timer.
module tick_divider #(
    parameter int MOD = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);
    localparam int CW = (MOD > 1) ? $clog2(MOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(MOD - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end
endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller: one decoder shared by N_DIGITS digits, with frame
// snapshots, anti-ghosting blanking, blink masking and leading-zero suppression.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int   N_DIGITS     = 6,
    parameter int   CLK_HZ       = 50_000_000,
    parameter int   SCAN_HZ      = 1000,
    parameter int   BLANK_CYCLES = 500,
    parameter int   BLINK_HZ     = 2,
    parameter logic AN_ACTIVE    = 1'b0,
    parameter logic DP_ACTIVE    = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    display_scan_ctrl_if.slave  bus,
    output scan_state_t         dbg_state
);
    localparam int DIV        = calc_div(CLK_HZ, SCAN_HZ);
    localparam int BLINK_HALF = calc_blink_half(CLK_HZ, BLINK_HZ);
    localparam int IDX_W      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int BLANK_W    = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam int BLANK_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    // run is low only on the first edge out of reset, which forces a slot-0 boundary.
    logic                  run;
    logic                  slot_tick;
    logic                  blink_tick;
    logic                  boundary;
    logic                  frame_edge;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_nxt;
    scan_state_t           state;
    scan_state_t           state_nxt;
    logic [BLANK_W-1:0]    blank_cnt;
    logic [BLANK_W-1:0]    blank_cnt_nxt;
    logic                  blink_phase;
    logic                  blink_hold;
    logic [4*N_DIGITS-1:0] snap_digits;
    logic [N_DIGITS-1:0]   snap_dp;
    logic [N_DIGITS-1:0]   snap_mask;
    logic                  snap_lz;
    logic [4*N_DIGITS-1:0] src_digits;
    logic [N_DIGITS-1:0]   src_dp;
    logic [N_DIGITS-1:0]   src_mask;
    logic                  src_lz;
    logic [N_DIGITS-1:0]   upper_zero;
    logic [3:0]            sel_digit;
    logic [3:0]            bcd_nxt;
    logic [3:0]            bcd_q;
    logic                  dp_q;
    logic                  fs_q;
    logic [N_DIGITS-1:0]   an_c;

    tick_divider #(.MOD(DIV)) u_slot_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (run),
        .tick  (slot_tick)
    );

    tick_divider #(.MOD(BLINK_HALF)) u_blink_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .tick  (blink_tick)
    );

    assign boundary   = !run || slot_tick;
    assign idx_nxt    = (!run || idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    assign frame_edge = boundary && (idx_nxt == '0);

    // At a frame boundary the slot-0 outputs must come from the values being captured now.
    assign src_digits = frame_edge ? bus.digits     : snap_digits;
    assign src_dp     = frame_edge ? bus.dp_in      : snap_dp;
    assign src_mask   = frame_edge ? bus.blink_mask : snap_mask;
    assign src_lz     = frame_edge ? bus.lz_en      : snap_lz;

    always_comb begin
        logic z;
        z          = 1'b1;
        upper_zero = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            z             = z && (src_digits[4*i +: 4] == 4'd0);
            upper_zero[i] = z;
        end
    end

    always_comb begin
        sel_digit = src_digits[4*int'(idx_nxt) +: 4];
        bcd_nxt   = blank_invalid(sel_digit);
        if (src_lz && (idx_nxt != '0) && upper_zero[idx_nxt]) begin
            bcd_nxt = BLANK_CODE;
        end
    end

    always_comb begin
        state_nxt     = state;
        blank_cnt_nxt = blank_cnt;
        if (boundary) begin
            blank_cnt_nxt = '0;
            state_nxt     = (BLANK_CYCLES == 0) ? S_DRIVE : S_BLANK;
        end else if (state == S_BLANK) begin
            if (blank_cnt == BLANK_W'(BLANK_LAST)) begin
                state_nxt = S_DRIVE;
            end else begin
                blank_cnt_nxt = blank_cnt + BLANK_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_BLANK;
            blank_cnt <= '0;
        end else begin
            state     <= state_nxt;
            blank_cnt <= blank_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run         <= 1'b0;
            idx         <= '0;
            blink_phase <= 1'b0;
            blink_hold  <= 1'b0;
            snap_digits <= '0;
            snap_dp     <= '0;
            snap_mask   <= '0;
            snap_lz     <= 1'b0;
            bcd_q       <= BLANK_CODE;
            dp_q        <= ~DP_ACTIVE;
            fs_q        <= 1'b0;
        end else begin
            run  <= 1'b1;
            fs_q <= frame_edge;
            if (blink_tick) begin
                blink_phase <= ~blink_phase;
            end
            // Blink suppression is decided once per slot so a digit is dark for a whole slot.
            if (boundary) begin
                idx        <= idx_nxt;
                bcd_q      <= bcd_nxt;
                dp_q       <= src_dp[idx_nxt] ? DP_ACTIVE : ~DP_ACTIVE;
                blink_hold <= blink_phase && src_mask[idx_nxt];
            end
            if (frame_edge) begin
                snap_digits <= bus.digits;
                snap_dp     <= bus.dp_in;
                snap_mask   <= bus.blink_mask;
                snap_lz     <= bus.lz_en;
            end
        end
    end

    always_comb begin
        an_c = {N_DIGITS{~AN_ACTIVE}};
        if (state == S_DRIVE && !blink_hold) begin
            an_c[idx] = AN_ACTIVE;
        end
    end

    assign bus.an          = an_c;
    assign bus.bcd_out     = bcd_q;
    assign bus.dp_out      = dp_q;
    assign bus.frame_start = fs_q;
    assign dbg_state       = state;
endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Time-multiplexed scan controller for the clock's multi-digit seven-segment display.
- Shares a single seven_seg_decoder instance across N_DIGITS digits. Each scan slot it presents one digit's BCD value to the decoder and drives that digit's enable line.
- Takes a frame snapshot of the digit bus, so a digit never tears mid-frame.
- Adds anti-ghosting blanking, a blink mask for time-setting mode, and optional leading-zero suppression.

Parameters:
- N_DIGITS, 6, number of multiplexed digits (HH:MM:SS); legal range 2..8.
- CLK_HZ, 50_000_000, system clock frequency.
- SCAN_HZ, 1000, slot rate in Hz; slot length DIV = CLK_HZ/SCAN_HZ cycles; DIV must be greater than BLANK_CYCLES.
- BLANK_CYCLES, 500, cycles at the start of each slot during which all digit enables are inactive; 0 is legal and means no blanking.
- BLINK_HZ, 2, blink rate; blink half-period = CLK_HZ/(2*BLINK_HZ) cycles.
- AN_ACTIVE, 1'b0, active level of the an outputs.
- DP_ACTIVE, 1'b0, active level of dp_out.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- digits  in  4*N_DIGITS  BCD digits; digit i occupies bits [4i+3:4i]; digit N_DIGITS-1 is leftmost.
- dp_in  in  N_DIGITS  decimal point request per digit; 1 = lit.
- blink_mask  in  N_DIGITS  1 = the digit blinks.
- lz_en  in  1  enables leading-zero suppression.
- bcd_out  out  4  to seven_seg_decoder data_in; 4'hF blanks the digit.
- an  out  N_DIGITS  one-hot digit enables at AN_ACTIVE level.
- dp_out  out  1  decimal point for the active digit.
- frame_start  out  1  one-cycle pulse when slot 0 begins.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - slot counter = 0, idx = 0, state = BLANK, blink counter = 0, blink_phase = 0.
  - Snapshot registers are cleared to 0.
  - Outputs: an = all inactive (~AN_ACTIVE), bcd_out = 4'hF, dp_out = ~DP_ACTIVE, frame_start = 0.
  - On the first edge after release, the controller starts a slot 0 boundary: snapshot, frame_start=1, idx=0.
  - Reset asserted mid-slot aborts the slot immediately with the reset values above.
- State machine:
  - BLANK: an all inactive; lasts BLANK_CYCLES cycles (0 cycles means skip directly to DRIVE).
  - DRIVE: an[idx] = AN_ACTIVE, unless the digit is blink-suppressed; lasts DIV-BLANK_CYCLES cycles.
  - DRIVE -> BLANK on slot expiry; idx advances, wrapping N_DIGITS-1 -> 0.
- Slot boundary register updates (all on the same edge):
  - bcd_out and dp_out update to the new idx.
  - These outputs hold for the whole slot, so the decoder output is stable before an asserts.
- Frame snapshot:
  - On each boundary into idx 0, digits, dp_in, blink_mask and lz_en are registered. frame_start pulses on that edge.
  - Input changes between snapshots have no effect until the next frame.
- bcd_out selection for the slot:
  - Snapshot digit value > 9 → 4'hF.
  - Leading-zero suppression (snapshot lz_en=1): digit i is blanked (4'hF) iff all snapshot digits j ≥ i equal 0 and i ≠ 0. Digit 0 is never suppressed.
  - dp_out is active iff snapshot dp bit is 1, independent of blanking.
- Blink:
  - Free-running counter toggles blink_phase every half-period; it is not reset by frames.
  - While blink_phase=1 and the snapshot mask bit is set, an stays inactive for that digit's whole slot. bcd_out is still driven.
- Counter widths: $clog2 of the maximum count, minimum 1 bit; arithmetic is unsigned.
- Invariant: an is never more than one-hot. The same-edge case (reset vs. slot expiry) resolves to reset.

Decomposition:
- Shared package display_pkg holds:
  - BLANK_CODE = 4'hF
  - localparam helpers for DIV and BLINK_HALF
  - the scan state enum {S_BLANK, S_DRIVE}
- One natural sub-module: tick_divider (parameterised modulus counter emitting a one-cycle tick), instantiated twice:
  - slot expiry timer
  - blink half-period timer

Test Plan:
- Bench parameters: N_DIGITS=4, CLK_HZ=1000, SCAN_HZ=100 (DIV=10), BLANK_CYCLES=2, BLINK_HZ=25 (half-period 20), AN_ACTIVE=0.
- Reset release, digits=16'h1234 → frame_start at cycle 1; an=4'b1111 for 2 cycles, then 4'b1110 for 8 cycles with bcd_out=4; next slot an=4'b1101 with bcd_out=3; order 4,3,2,1 repeats every 40 cycles.
- Change digits to 16'h5678 mid-frame (during idx 2) → remaining slots still show 2,1; next frame shows 8,7,6,5.
- lz_en=1, digits=16'h0030 → idx3 and idx2 get bcd_out=F; idx1=3; idx0=0 shown. With digits=16'h0000, only idx0 shows 0.
- blink_mask=4'b0011 → digits 0,1 an inactive during alternating 20-cycle windows; bcd_out unchanged; digits 2,3 unaffected.
- Digit value 4'hC, and dp_in=4'b0100 → bcd_out=F for that digit; dp_out=0 only during the idx2 slot.
- Assert rst_n=0 for one cycle mid-DRIVE → next cycle an=4'b1111, bcd_out=F; restart at idx0 with frame_start. Continuous assertion check: an never has more than one bit active.
